game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer for the escape game. It consumes one-cycle menu button pulses and gameplay event pulses from the player and collision logic. It drives the screen `state`, key count, life, current task and stage-unlock mask that the UI overlay renderer draws. It owns every screen transition and all per-stage progress bookkeeping.

## Interface
- `INVULN_CYCLES`, default 50_000_000: hazard-immunity window after a stage-3 hit, in clk cycles (≥1, fits 32 bits).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_up` in 1: menu cursor up, one-cycle pulse.
- `btn_down` in 1: menu cursor down, one-cycle pulse.
- `btn_enter` in 1: menu select, one-cycle pulse.
- `btn_esc` in 1: abandon stage, one-cycle pulse.
- `key_hit` in 1: player touched a key, pulse.
- `light_hit` in 1: player reached the light switch, pulse.
- `door_hit` in 1: player at the exit door, pulse.
- `hazard_hit` in 1: player touched a hazard, pulse.
- `state` out 4: screen code. TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8, HELP=9.
- `key_find` out 2: keys collected, 0..3.
- `life` out 2: remaining lives, 0..3.
- `todo` out 2: current task. NONE=0, FIND_KEY=1, FIND_LIGHT=2, FIND_DOOR=3.
- `play_valid` out 4: stage unlock mask. Bit2 means stage 2 is playable; bit3 means stage 3 is playable.
- `cursor` out 2: highlighted menu item on the current screen.
- `stage_start` out 1: one-cycle pulse on the cycle a STAGEn state is entered. Map logic uses it to reset player position.

## Operation
- All outputs are registered. Reset values:
  - `state`=TITLE, `cursor`=0, `key_find`=0, `life`=0, `todo`=NONE.
  - `play_valid`=4'b0011, `stage_start`=0, invulnerability counter=0.
- Cursor range per screen:
  - TITLE: 0..3 (stage1, stage2, stage3, help).
  - SUCCESS1/2 and FAIL: 0..1.
  - All other screens: 0.
- Cursor movement: `btn_up` decrements and `btn_down` increments, both wrapping within the range. Both pressed in the same cycle: no change.
- `cursor` clears to 0 on every state change.
- `btn_enter` has priority over up/down in the same cycle.
- TITLE + enter:
  - cursor0 → STAGE1.
  - cursor1 → STAGE2 only if `play_valid[2]`, else stay in TITLE.
  - cursor2 → STAGE3 only if `play_valid[3]`, else stay in TITLE.
  - cursor3 → HELP.
- HELP + enter → TITLE. STAFF + enter → TITLE.
- On stage entry:
  - `key_find`=0 and `stage_start`=1.
  - `todo`=FIND_LIGHT for STAGE2, FIND_KEY otherwise.
  - `life`=3 for STAGE3, 0 otherwise.
  - Invulnerability counter cleared.
- Stage event handling, in priority order (one event acted on per cycle):
  1. `btn_esc` → TITLE, with `todo`=NONE.
  2. `hazard_hit`, STAGE3 only, and only while the invulnerability counter is 0:
     - life>1: decrement life and load the counter with `INVULN_CYCLES`.
     - life==1: life=0 and go to FAIL.
  3. `door_hit` with `todo`==FIND_DOOR → SUCCESSn, with `todo`=NONE.
  4. `light_hit` with `todo`==FIND_LIGHT → `todo`=FIND_KEY.
  5. `key_hit` with `todo`==FIND_KEY → key_find+1. If the new value is 3, `todo`=FIND_DOOR on the same edge.
- Any event whose `todo` condition does not hold is ignored. `key_find` never exceeds 3.
- The invulnerability counter decrements by 1 each cycle while nonzero, in STAGE3 only. It is cleared on leaving STAGE3.
- Entering SUCCESS1 sets `play_valid[2]`. Entering SUCCESS2 sets `play_valid[3]`. Bits are only cleared by reset.
- SUCCESS1/2 + enter: cursor0 → next stage (STAGE2/STAGE3), cursor1 → TITLE.
- SUCCESS3 + enter → STAFF.
- FAIL + enter: cursor0 → STAGE3 (retry, full re-entry initialisation), cursor1 → TITLE.
- Gameplay pulses are ignored outside STAGEn. Menu up/down/enter are ignored inside STAGEn.
- `key_find` and `life` hold their values in SUCCESSn/FAIL. They are cleared on entry to TITLE.

## Timing
- Every response appears on the first rising clk edge after the input pulse. All state and outputs change on that same edge.
- `stage_start` is high exactly one cycle, coincident with the first cycle `state`==STAGEn.
- Invulnerability: a hazard accepted at edge T blocks further hazards through the edge at T+`INVULN_CYCLES`. A hazard at edge T+`INVULN_CYCLES`+1 is accepted.
- `rst_n` low at any time, including mid-stage: all outputs go to their reset values immediately (asynchronously) and hold until `rst_n` rises. The first transition can happen on the second edge after the release.

## Test plan
- Reset then TITLE: press down×2, enter → state stays 0, `cursor`=2. Press down, enter → state=9 (HELP). Enter → state=0, `cursor`=0.
- STAGE1 flow: 3×`key_hit` → `key_find` 1,2,3 and `todo`=3 on the third edge. An extra `key_hit` leaves `key_find` at 3. `door_hit` → state=3 and `play_valid`=4'b0111.
- STAGE2: `key_hit` before `light_hit` is ignored (`key_find`=0). `light_hit` → `todo`=1. Then 3 keys and door → state=5 and `play_valid`=4'b1111.
- STAGE3 with `INVULN_CYCLES`=4:
  - Hazards at cycles 0, 2, 5 → `life` 3→2 at cycle 0, unchanged at cycle 2, 2→1 at cycle 5.
  - A further hazard once the window has expired → state=8 and `life`=0.
  - FAIL + enter with `cursor`=0 → state=6, `life`=3, `stage_start` pulse.
- Same-cycle `hazard_hit`+`door_hit` in STAGE3 with `todo`=FIND_DOOR and `life`=1 → FAIL, not SUCCESS3.
- Mid-STAGE2, assert `rst_n` low for 1 cycle → state=0, `play_valid`=4'b0011, all counters 0, with no clock edge required.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: screen sequencer for the escape game.
// Owns menu cursor, per-stage progress (keys, lives, task) and the stage unlock mask.
module game_flow_ctrl #(
  parameter int unsigned INVULN_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       btn_esc,
  input  logic       key_hit,
  input  logic       light_hit,
  input  logic       door_hit,
  input  logic       hazard_hit,
  output logic [3:0] state,
  output logic [1:0] key_find,
  output logic [1:0] life,
  output logic [1:0] todo,
  output logic [3:0] play_valid,
  output logic [1:0] cursor,
  output logic       stage_start
);

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8,
    ST_HELP     = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    TODO_NONE  = 2'd0,
    TODO_KEY   = 2'd1,
    TODO_LIGHT = 2'd2,
    TODO_DOOR  = 2'd3
  } todo_e;

  localparam logic [31:0] INVULN_LOAD = 32'(INVULN_CYCLES);

  state_e      state_q, state_d;
  todo_e       todo_q, todo_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [1:0]  key_find_q, key_find_d;
  logic [1:0]  life_q, life_d;
  logic [3:0]  play_valid_q, play_valid_d;
  logic        stage_start_q, stage_start_d;
  logic [31:0] invuln_q, invuln_d;
  logic [1:0]  cursor_max;
  logic        in_stage;

  always_comb begin
    in_stage = (state_q == ST_STAGE1) || (state_q == ST_STAGE2) || (state_q == ST_STAGE3);
    case (state_q)
      ST_TITLE:                          cursor_max = 2'd3;
      ST_SUCCESS1, ST_SUCCESS2, ST_FAIL: cursor_max = 2'd1;
      default:                           cursor_max = 2'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    todo_d        = todo_q;
    cursor_d      = cursor_q;
    key_find_d    = key_find_q;
    life_d        = life_q;
    play_valid_d  = play_valid_q;
    stage_start_d = 1'b0;
    invuln_d      = (state_q == ST_STAGE3 && invuln_q != '0) ? invuln_q - 32'd1 : invuln_q;

    if (in_stage) begin
      // One gameplay event per cycle; a blocked hazard falls through to the next event.
      if (btn_esc) begin
        state_d = ST_TITLE;
      end else if (hazard_hit && state_q == ST_STAGE3 && invuln_q == '0) begin
        if (life_q > 2'd1) begin
          life_d   = life_q - 2'd1;
          invuln_d = INVULN_LOAD;
        end else begin
          life_d  = 2'd0;
          state_d = ST_FAIL;
        end
      end else if (door_hit && todo_q == TODO_DOOR) begin
        todo_d = TODO_NONE;
        case (state_q)
          ST_STAGE1: state_d = ST_SUCCESS1;
          ST_STAGE2: state_d = ST_SUCCESS2;
          default:   state_d = ST_SUCCESS3;
        endcase
      end else if (light_hit && todo_q == TODO_LIGHT) begin
        todo_d = TODO_KEY;
      end else if (key_hit && todo_q == TODO_KEY) begin
        key_find_d = key_find_q + 2'd1;
        if (key_find_q == 2'd2) todo_d = TODO_DOOR;
      end
    end else if (btn_enter) begin
      case (state_q)
        ST_TITLE: begin
          case (cursor_q)
            2'd0:    state_d = ST_STAGE1;
            2'd1:    if (play_valid_q[2]) state_d = ST_STAGE2;
            2'd2:    if (play_valid_q[3]) state_d = ST_STAGE3;
            default: state_d = ST_HELP;
          endcase
        end
        ST_HELP, ST_STAFF: state_d = ST_TITLE;
        ST_SUCCESS1:       state_d = (cursor_q == 2'd0) ? ST_STAGE2 : ST_TITLE;
        ST_SUCCESS2:       state_d = (cursor_q == 2'd0) ? ST_STAGE3 : ST_TITLE;
        ST_SUCCESS3:       state_d = ST_STAFF;
        ST_FAIL:           state_d = (cursor_q == 2'd0) ? ST_STAGE3 : ST_TITLE;
        default:           state_d = state_q;
      endcase
    end else if (btn_up && !btn_down) begin
      cursor_d = (cursor_q == 2'd0) ? cursor_max : cursor_q - 2'd1;
    end else if (btn_down && !btn_up) begin
      cursor_d = (cursor_q >= cursor_max) ? 2'd0 : cursor_q + 2'd1;
    end

    // Entry actions shared by every path into a given screen.
    if (state_d != state_q) begin
      cursor_d = 2'd0;
      case (state_d)
        ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
          key_find_d    = 2'd0;
          stage_start_d = 1'b1;
          todo_d        = (state_d == ST_STAGE2) ? TODO_LIGHT : TODO_KEY;
          life_d        = (state_d == ST_STAGE3) ? 2'd3 : 2'd0;
        end
        ST_TITLE: begin
          key_find_d = 2'd0;
          life_d     = 2'd0;
          todo_d     = TODO_NONE;
        end
        ST_SUCCESS1: play_valid_d[2] = 1'b1;
        ST_SUCCESS2: play_valid_d[3] = 1'b1;
        default: ;
      endcase
    end

    if (state_d != ST_STAGE3 || state_d != state_q) invuln_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_TITLE;
      todo_q        <= TODO_NONE;
      cursor_q      <= 2'd0;
      key_find_q    <= 2'd0;
      life_q        <= 2'd0;
      play_valid_q  <= 4'b0011;
      stage_start_q <= 1'b0;
      invuln_q      <= '0;
    end else begin
      state_q       <= state_d;
      todo_q        <= todo_d;
      cursor_q      <= cursor_d;
      key_find_q    <= key_find_d;
      life_q        <= life_d;
      play_valid_q  <= play_valid_d;
      stage_start_q <= stage_start_d;
      invuln_q      <= invuln_d;
    end
  end

  assign state       = state_q;
  assign todo        = todo_q;
  assign cursor      = cursor_q;
  assign key_find    = key_find_q;
  assign life        = life_q;
  assign play_valid  = play_valid_q;
  assign stage_start = stage_start_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed walkthrough plus random pulses
// compared every cycle against a screen-level behavioural model.
module tb_game_flow_ctrl;

  localparam int N = 4;
  localparam logic [7:0] UP   = 8'h01;
  localparam logic [7:0] DN   = 8'h02;
  localparam logic [7:0] ENT  = 8'h04;
  localparam logic [7:0] ESC  = 8'h08;
  localparam logic [7:0] KEY  = 8'h10;
  localparam logic [7:0] LGT  = 8'h20;
  localparam logic [7:0] DOOR = 8'h40;
  localparam logic [7:0] HAZ  = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0, btn_esc = 1'b0;
  logic key_hit = 1'b0, light_hit = 1'b0, door_hit = 1'b0, hazard_hit = 1'b0;
  logic [3:0] state;
  logic [1:0] key_find;
  logic [1:0] life;
  logic [1:0] todo;
  logic [3:0] play_valid;
  logic [1:0] cursor;
  logic       stage_start;

  int nCompared = 0;
  int nMismatched = 0;

  int         mState, mCursor, mKey, mLife, mTodo, mStart;
  logic [3:0] mPv;
  longint     cyc = 0;
  longint     lastHit = -1000;

  always #5 clk = ~clk;

  game_flow_ctrl #(.INVULN_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .btn_esc(btn_esc),
    .key_hit(key_hit), .light_hit(light_hit), .door_hit(door_hit), .hazard_hit(hazard_hit),
    .state(state), .key_find(key_find), .life(life), .todo(todo),
    .play_valid(play_valid), .cursor(cursor), .stage_start(stage_start)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    @(negedge clk);
    {hazard_hit, door_hit, light_hit, key_hit, btn_esc, btn_enter, btn_down, btn_up} = v;
    @(posedge clk);
    #2;
    {hazard_hit, door_hit, light_hit, key_hit, btn_esc, btn_enter, btn_down, btn_up} = 8'h00;
  endtask

  task automatic modelReset();
    mState = 0; mCursor = 0; mKey = 0; mLife = 0; mTodo = 0; mStart = 0;
    mPv = 4'b0011;
    lastHit = -1000;
  endtask

  // Screen-level rules; invulnerability is tracked as a timestamp of the last accepted hit.
  task automatic modelStep();
    int nxt;
    int span;
    bit inStage;
    cyc++;
    nxt = mState;
    mStart = 0;
    inStage = (mState == 2 || mState == 4 || mState == 6);
    span = (mState == 0) ? 4 : ((mState == 3 || mState == 5 || mState == 8) ? 2 : 1);
    if (inStage) begin
      if (btn_esc) nxt = 0;
      else if (hazard_hit && mState == 6 && (cyc - lastHit) > N) begin
        if (mLife > 1) begin
          mLife--;
          lastHit = cyc;
        end else begin
          mLife = 0;
          nxt = 8;
        end
      end else if (door_hit && mTodo == 3) begin
        nxt = mState + 1;
        mTodo = 0;
      end else if (light_hit && mTodo == 2) mTodo = 1;
      else if (key_hit && mTodo == 1) begin
        mKey++;
        if (mKey == 3) mTodo = 3;
      end
    end else if (btn_enter) begin
      case (mState)
        0: begin
          if (mCursor == 0) nxt = 2;
          else if (mCursor == 1) begin if (mPv[2]) nxt = 4; end
          else if (mCursor == 2) begin if (mPv[3]) nxt = 6; end
          else nxt = 9;
        end
        1, 9: nxt = 0;
        3: nxt = (mCursor == 0) ? 4 : 0;
        5, 8: nxt = (mCursor == 0) ? 6 : 0;
        7: nxt = 1;
        default: nxt = mState;
      endcase
    end else if (btn_up != btn_down) begin
      mCursor = (mCursor + (btn_down ? 1 : span - 1)) % span;
    end
    if (nxt != mState) begin
      mCursor = 0;
      if (nxt == 2 || nxt == 4 || nxt == 6) begin
        mKey = 0;
        mStart = 1;
        mTodo = (nxt == 4) ? 2 : 1;
        mLife = (nxt == 6) ? 3 : 0;
        lastHit = -1000;
      end
      if (nxt == 0) begin
        mKey = 0; mLife = 0; mTodo = 0;
      end
      if (nxt == 3) mPv = mPv | 4'b0100;
      if (nxt == 5) mPv = mPv | 4'b1000;
      mState = nxt;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) modelReset();
      else modelStep();
      #1;
      checkOutput("state", state, mState);
      checkOutput("cursor", cursor, mCursor);
      checkOutput("key_find", key_find, mKey);
      checkOutput("life", life, mLife);
      checkOutput("todo", todo, mTodo);
      checkOutput("play_valid", play_valid, mPv);
      checkOutput("stage_start", stage_start, mStart);
    end
  end

  initial begin
    logic [7:0] v;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_play_valid", play_valid, 4'b0011);
    checkOutput("rst_cursor", cursor, 0);

    applyStimulus(DN); applyStimulus(DN); applyStimulus(ENT);
    checkOutput("title_locked_state", state, 0);
    checkOutput("title_locked_cursor", cursor, 2);
    applyStimulus(DN); applyStimulus(ENT);
    checkOutput("help_state", state, 9);
    applyStimulus(ENT);
    checkOutput("help_back_state", state, 0);
    checkOutput("help_back_cursor", cursor, 0);

    applyStimulus(ENT);
    checkOutput("s1_state", state, 2);
    checkOutput("s1_start", stage_start, 1);
    checkOutput("s1_todo", todo, 1);
    applyStimulus(8'h00);
    checkOutput("s1_start_drop", stage_start, 0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(KEY);
      checkOutput("s1_keys", key_find, k);
    end
    checkOutput("s1_todo_door", todo, 3);
    applyStimulus(KEY);
    checkOutput("s1_key_sat", key_find, 3);
    applyStimulus(DOOR);
    checkOutput("s1_success", state, 3);
    checkOutput("s1_unlock", play_valid, 4'b0111);

    applyStimulus(ENT);
    checkOutput("s2_state", state, 4);
    checkOutput("s2_todo", todo, 2);
    applyStimulus(KEY);
    checkOutput("s2_key_early", key_find, 0);
    applyStimulus(LGT);
    checkOutput("s2_todo_key", todo, 1);
    repeat (3) applyStimulus(KEY);
    applyStimulus(DOOR);
    checkOutput("s2_success", state, 5);
    checkOutput("s2_unlock", play_valid, 4'b1111);

    applyStimulus(ENT);
    checkOutput("s3_state", state, 6);
    checkOutput("s3_life", life, 3);
    applyStimulus(HAZ);
    checkOutput("haz_c0", life, 2);
    applyStimulus(8'h00);
    applyStimulus(HAZ);
    checkOutput("haz_c2_blocked", life, 2);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(HAZ);
    checkOutput("haz_c5", life, 1);
    repeat (5) applyStimulus(8'h00);
    applyStimulus(HAZ);
    checkOutput("haz_fail_state", state, 8);
    checkOutput("haz_fail_life", life, 0);
    applyStimulus(ENT);
    checkOutput("retry_state", state, 6);
    checkOutput("retry_life", life, 3);
    checkOutput("retry_start", stage_start, 1);

    applyStimulus(HAZ);
    repeat (5) applyStimulus(8'h00);
    applyStimulus(HAZ);
    checkOutput("s3_life_one", life, 1);
    repeat (5) applyStimulus(8'h00);
    repeat (3) applyStimulus(KEY);
    checkOutput("s3_todo_door", todo, 3);
    applyStimulus(HAZ | DOOR);
    checkOutput("haz_over_door", state, 8);
    checkOutput("haz_over_door_life", life, 0);

    applyStimulus(DN); applyStimulus(ENT);
    checkOutput("fail_title", state, 0);
    checkOutput("fail_title_life", life, 0);
    applyStimulus(DN); applyStimulus(ENT);
    checkOutput("title_s2", state, 4);
    applyStimulus(LGT); applyStimulus(KEY);
    checkOutput("s2b_key", key_find, 1);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_state", state, 0);
    checkOutput("async_rst_pv", play_valid, 4'b0011);
    checkOutput("async_rst_key", key_find, 0);
    checkOutput("async_rst_life", life, 0);
    checkOutput("async_rst_todo", todo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        v = 8'h00;
        if ($urandom_range(0, 9) == 0)  v = v | UP;
        if ($urandom_range(0, 9) == 0)  v = v | DN;
        if ($urandom_range(0, 6) == 0)  v = v | ENT;
        if ($urandom_range(0, 49) == 0) v = v | ESC;
        if ($urandom_range(0, 4) == 0)  v = v | KEY;
        if ($urandom_range(0, 9) == 0)  v = v | LGT;
        if ($urandom_range(0, 9) == 0)  v = v | DOOR;
        if ($urandom_range(0, 9) == 0)  v = v | HAZ;
        applyStimulus(v);
      end
    end

    repeat (2) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
